// File: rtl/imem_pkg.sv
// Shared types and constants for the runtime-loadable instruction memory.
// Optional read parity is enabled with the IMEM_PARITY_EN macro.
package imem_pkg;
   localparam int unsigned LD_BYTE_W   = 8;
   localparam logic [15:0] NOP_DEFAULT = 16'h0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } ld_state_e;

   function automatic int unsigned bytes_per_word(input int unsigned data_w);
      return data_w / LD_BYTE_W;
   endfunction
endpackage

// File: rtl/prog_instr_mem_if.sv
// Fetch and byte-serial program-load bus of the instruction memory.
// The optional IMEM_PARITY_EN feature only affects the parity_err value.
interface prog_instr_mem_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned PC_W   = 16,
   parameter int unsigned ADDR_W = 8
);
   logic [PC_W-1:0]   pc;
   logic              fetch_en;
   logic              stall;
   logic [DATA_W-1:0] instruction;
   logic              instr_valid;
   logic              ld_start;
   logic [ADDR_W:0]   ld_count;
   logic [7:0]        ld_byte;
   logic              ld_valid;
   logic              ld_ready;
   logic              busy;
   logic              ld_done;
   logic              parity_err;

   modport slave (
      input  pc, fetch_en, stall, ld_start, ld_count, ld_byte, ld_valid,
      output instruction, instr_valid, ld_ready, busy, ld_done, parity_err
   );

   modport master (
      output pc, fetch_en, stall, ld_start, ld_count, ld_byte, ld_valid,
      input  instruction, instr_valid, ld_ready, busy, ld_done, parity_err
   );
endinterface

// File: rtl/imem_load_fsm.sv
// Program-load state machine: assembles MSB-first bytes into words and
// issues one write strobe per completed word. No macro dependencies.
module imem_load_fsm
   import imem_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ld_start,
   input  logic [ADDR_W:0]      ld_count,
   input  logic [LD_BYTE_W-1:0] ld_byte,
   input  logic                 ld_valid,
   output logic                 ld_ready,
   output logic                 busy,
   output logic                 ld_done,
   output logic                 idle,
   output logic                 start_acc,
   output logic                 wr_en,
   output logic [ADDR_W-1:0]    wr_addr,
   output logic [DATA_W-1:0]    wr_data
);
   localparam int unsigned BPW    = bytes_per_word(DATA_W);
   localparam int unsigned BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BPW - 1);
   localparam logic [BIDX_W-1:0] BIDX_ONE  = BIDX_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

   ld_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BIDX_W-1:0] bidx_q, bidx_d;
   logic [DATA_W-1:0] asm_q, asm_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic              ld_ready_q, ld_ready_d;
   logic              busy_q, busy_d;
   logic              ld_done_q, ld_done_d;
   logic              idle_q, idle_d;
   logic [ADDR_W:0]   cnt_sat;
   logic [DATA_W-1:0] word_nx;

   always_comb begin
      cnt_sat   = (ld_count > DEPTH_CNT) ? DEPTH_CNT : ld_count;
      start_acc = (state_q == ST_IDLE) && ld_start;
      // Older bytes shift out of the top, so no clear is needed between words.
      word_nx   = DATA_W'({asm_q, ld_byte});

      state_d = state_q;
      addr_d  = addr_q;
      bidx_d  = bidx_q;
      asm_d   = asm_q;
      rem_d   = rem_q;
      wr_en   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ld_start) begin
               addr_d = '0;
               bidx_d = '0;
               rem_d  = cnt_sat;
               state_d = (cnt_sat != '0) ? ST_LOAD : ST_DONE;
            end
         end
         ST_LOAD: begin
            if (ld_valid && ld_ready_q) begin
               asm_d = word_nx;
               if (bidx_q == LAST_BYTE) begin
                  bidx_d = '0;
                  wr_en  = 1'b1;
                  addr_d = addr_q + ADDR_ONE;
                  rem_d  = rem_q - CNT_ONE;
                  if (rem_q == CNT_ONE) state_d = ST_DONE;
               end else begin
                  bidx_d = bidx_q + BIDX_ONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      ld_ready_d = (state_d == ST_LOAD);
      busy_d     = (state_d == ST_LOAD);
      ld_done_d  = (state_d == ST_DONE);
      idle_d     = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         bidx_q     <= '0;
         asm_q      <= '0;
         rem_q      <= '0;
         ld_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         ld_done_q  <= 1'b0;
         idle_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         bidx_q     <= bidx_d;
         asm_q      <= asm_d;
         rem_q      <= rem_d;
         ld_ready_q <= ld_ready_d;
         busy_q     <= busy_d;
         ld_done_q  <= ld_done_d;
         idle_q     <= idle_d;
      end
   end

   assign ld_ready = ld_ready_q;
   assign busy     = busy_q;
   assign ld_done  = ld_done_q;
   assign idle     = idle_q;
   assign wr_addr  = addr_q;
   assign wr_data  = word_nx;
endmodule

// File: rtl/prog_instr_mem.sv
// Runtime-loadable instruction memory with registered fetch port.
// Define IMEM_PARITY_EN to store and check a per-word even-parity bit.
module prog_instr_mem
   import imem_pkg::*;
#(
   parameter int unsigned       DATA_W   = 16,
   parameter int unsigned       PC_W     = 16,
   parameter int unsigned       ADDR_W   = 8,
   parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
   input logic              clk,
   input logic              rst_n,
   prog_instr_mem_if.slave  bus
);
   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH] = '{default: NOP_WORD};

   logic              idle, start_acc, wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] rd_idx;
   logic [DATA_W-1:0] rd_word;
   logic              in_range, fetch_go;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic              valid_q, valid_d;
   logic              perr_q, perr_d;

   imem_load_fsm #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_load_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_start  (bus.ld_start),
      .ld_count  (bus.ld_count),
      .ld_byte   (bus.ld_byte),
      .ld_valid  (bus.ld_valid),
      .ld_ready  (bus.ld_ready),
      .busy      (bus.busy),
      .ld_done   (bus.ld_done),
      .idle      (idle),
      .start_acc (start_acc),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data)
   );

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   always_comb begin
      rd_idx   = bus.pc[ADDR_W-1:0];
      rd_word  = mem_q[rd_idx];
      in_range = ((bus.pc >> ADDR_W) == '0);
      fetch_go = idle && !bus.stall && bus.fetch_en;

      instr_d = instr_q;
      valid_d = valid_q;
      // Outside IDLE the fetch port is forced quiet, overriding stall.
      if (!idle) begin
         instr_d = NOP_WORD;
         valid_d = 1'b0;
      end else if (!bus.stall) begin
         instr_d = (bus.fetch_en && in_range) ? rd_word : NOP_WORD;
         valid_d = bus.fetch_en;
      end
   end

`ifdef IMEM_PARITY_EN
   logic par_mem_q [DEPTH] = '{default: ^NOP_WORD};

   always_ff @(posedge clk) begin
      if (wr_en) par_mem_q[wr_addr] <= ^wr_data;
   end

   always_comb begin
      perr_d = perr_q;
      if (start_acc)
         perr_d = 1'b0;
      else if (fetch_go && in_range && ((^rd_word) != par_mem_q[rd_idx]))
         perr_d = 1'b1;
   end
`else
   always_comb begin
      perr_d = 1'b0;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= NOP_WORD;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         instr_q <= instr_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
      end
   end

   assign bus.instruction = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.parity_err  = perr_q;
endmodule

// File: doc/prog_instr_mem.md
Name: prog_instr_mem

Overview:
Parametrised, runtime-loadable instruction memory for the 16-bit pipelined core. It replaces the hard-coded combinational program ROM. It provides a registered fetch port to the IF stage, with stall hold and out-of-range NOP fill, plus a byte-serial valid/ready program-load port driven by a load FSM. Fetch is blocked while a load is in progress.

Parameters:
DATA_W, 16, instruction width in bits; must be a multiple of 8
PC_W, 16, width of the pc input (word address)
ADDR_W, 8, memory index width; DEPTH = 2**ADDR_W words
NOP_WORD, 16'h0000, word returned on reset, when idle, while busy, and for out-of-range pc

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
pc  in  PC_W  word address from IF stage
fetch_en  in  1  request a fetch this cycle
stall  in  1  pipeline stall; hold fetch outputs
instruction  out  DATA_W  registered instruction
instr_valid  out  1  instruction holds a real fetched word
ld_start  in  1  one-cycle pulse; begin a load at word 0
ld_count  in  ADDR_W+1  number of words to load; sampled with ld_start
ld_byte  in  8  load data byte, most-significant byte first
ld_valid  in  1  ld_byte valid
ld_ready  out  1  block accepts ld_byte this cycle
busy  out  1  load in progress
ld_done  out  1  one-cycle pulse at load completion
parity_err  out  1  registered read parity error (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - instruction=NOP_WORD; instr_valid=0; ld_ready=0; busy=0; ld_done=0; parity_err=0.
  - FSM goes to IDLE; address counter and byte counter are cleared.
  - Memory array is not reset. It is initialised to NOP_WORD at time zero for simulation only.
- Fetch path (FSM in IDLE), evaluated on each rising edge:
  - stall=1: instruction and instr_valid hold, regardless of fetch_en.
  - stall=0, fetch_en=1: instruction <= mem[pc[ADDR_W-1:0]] if pc < DEPTH, else NOP_WORD; instr_valid <= 1.
  - stall=0, fetch_en=0: instruction <= NOP_WORD; instr_valid <= 0.
  - Latency is 1 cycle from pc to instruction.
- Load FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on ld_start=1 with ld_count != 0. On entry: word address=0, byte index=0.
  - IDLE -> DONE on ld_start with ld_count=0. No write occurs.
  - LOAD: ld_ready=1, busy=1.
    - A byte transfers when ld_valid && ld_ready.
    - Bytes fill the word from most-significant to least-significant.
    - On the DATA_W/8-th byte, the assembled word is written to mem[addr] in the same edge and addr increments.
    - After ld_count words are written, go to DONE.
  - DONE: busy=0, ld_ready=0, ld_done=1 for exactly one cycle, then IDLE.
- While busy=1: instruction=NOP_WORD, instr_valid=0; fetch_en and stall are ignored.
- ld_start is ignored while in LOAD or DONE.
- ld_count > DEPTH is saturated to DEPTH.
- Reset mid-load: words already written are retained; any partial word is discarded.
- No read/write collision is possible, because fetch is blocked during LOAD.
- First fetch after DONE returns the newly loaded data.

Optional Feature:
Macro IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on write.
  - On every fetch from an in-range address, stored parity is checked against the data. A mismatch sets parity_err=1 with the same timing as instruction.
  - parity_err is sticky until reset or the next ld_start.
- Undefined: no parity storage; parity_err is tied to 0.

Decomposition:
- Package imem_pkg holds:
  - the load FSM state enum (IDLE/LOAD/DONE);
  - NOP default constant;
  - LD_BYTE_W=8;
  - the bytes-per-word helper function.
- Sub-module imem_load_fsm contains the state machine, byte assembly, address counter, and ld_ready/busy/ld_done generation. It outputs wr_en, wr_addr and wr_data.
- The top level holds the array, the fetch register and the parity logic.

Test Plan:
1. Reset, then fetch with no load, pc=0..3 -> instr_valid=1 one cycle later, instruction=0000.
2. Load ld_count=3, bytes 80,40,80,81,02,98 with ld_valid gaps -> ld_done one pulse. Then fetch pc=0,1,2 -> 8040, 8081, 0298.
3. Fetch pc=1 then assert stall for 3 cycles with pc changing -> instruction stays 8081 and valid stays 1. Release stall -> new pc data next cycle.
4. Fetch pc=16'h0100 (>= DEPTH) -> instruction=0000, instr_valid=1.
5. Deassert rst_n after one byte of word 2 during a load -> outputs reset. Words 0 and 1 retain their values; word 2 is unchanged.
6. IMEM_PARITY_EN: force-flip one stored bit at pc=0, then fetch -> parity_err=1 and stays 1. ld_start clears it. Also cover ld_count=0 -> immediate ld_done.
